adpll_loop_ctrl: RTL and testbench

ADPLL_LOOP_CTRL -- requirements
Module: adpll_loop_ctrl

---
 rtl/adpll_pkg.sv | 32 +++
 rtl/adpll_flag_sync.sv | 21 ++
 rtl/adpll_loop_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_adpll_loop_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/adpll_pkg.sv
// Shared types and code-width-derived constants for the ADPLL loop controller.
package adpll_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_TRACK  = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DN   = 2'd2
    } dir_t;

    // Midscale DCO code: 2^(code_w-1)
    function automatic int unsigned mid_code(input int unsigned code_w);
        return 32'd1 << (code_w - 32'd1);
    endfunction

    // First binary-search step: 2^(code_w-2)
    function automatic int unsigned init_step(input int unsigned code_w);
        return 32'd1 << (code_w - 32'd2);
    endfunction

    // Step used when re-acquiring after losing lock: 2^(code_w-4)
    function automatic int unsigned reacq_step(input int unsigned code_w);
        return 32'd1 << (code_w - 32'd4);
    endfunction

endpackage

// File: rtl/adpll_flag_sync.sv
// Two-flop synchronizer bringing one asynchronous PFD flag into the IN_clk domain.
module adpll_flag_sync (
    input  logic IN_clk,
    input  logic reset,
    input  logic flag,
    output logic flag_sync
);

    logic meta;

    always_ff @(posedge IN_clk or negedge reset) begin
        if (!reset) begin
            meta      <= 1'b0;
            flag_sync <= 1'b0;
        end else begin
            meta      <= flag;
            flag_sync <= meta;
        end
    end

endmodule

// File: rtl/adpll_loop_ctrl.sv
// ADPLL loop controller: binary search for the DCO code, then +/-1 tracking with
// lock detection and re-acquisition on a sustained one-sided drift.
module adpll_loop_ctrl
    import adpll_pkg::*;
#(
    parameter int unsigned CODE_W     = 8,
    parameter int unsigned SETTLE     = 3,
    parameter int unsigned LOCK_CNT   = 8,
    parameter int unsigned UNLOCK_RUN = 4
) (
    input  logic              IN_clk,
    input  logic              reset,
    input  logic              flagU,
    input  logic              flagD,
    input  logic              freeze,
    output logic [CODE_W-1:0] dco_code,
    output logic              code_upd,
    output logic              lock,
    output logic [1:0]        state_o
);

    localparam int unsigned SET_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam int unsigned LCK_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned RUN_W = $clog2(UNLOCK_RUN + 1);

    localparam logic [CODE_W-1:0] MID_CODE   = CODE_W'(mid_code(CODE_W));
    localparam logic [CODE_W-1:0] INIT_STEP  = CODE_W'(init_step(CODE_W));
    localparam logic [CODE_W-1:0] REACQ_STEP = CODE_W'(reacq_step(CODE_W));
    localparam logic [SET_W-1:0]  SETTLE_LD  = SET_W'(SETTLE);
    localparam logic [LCK_W-1:0]  LOCK_TGT   = LCK_W'(LOCK_CNT);
    localparam logic [RUN_W-1:0]  RUN_TGT    = RUN_W'(UNLOCK_RUN);

    state_t            state_q,    state_d;
    dir_t              dir_q,      dir_d;
    logic [CODE_W-1:0] code_q,     code_d;
    logic [CODE_W-1:0] step_q,     step_d;
    logic [SET_W-1:0]  settle_q,   settle_d;
    logic [LCK_W-1:0]  lock_cnt_q, lock_cnt_d;
    logic [RUN_W-1:0]  run_cnt_q,  run_cnt_d;
    logic              upd_q,      upd_d;
    logic              lock_q,     lock_d;

    logic u_s;
    logic d_s;

    adpll_flag_sync u_sync_u (
        .IN_clk    (IN_clk),
        .reset     (reset),
        .flag      (flagU),
        .flag_sync (u_s)
    );

    adpll_flag_sync u_sync_d (
        .IN_clk    (IN_clk),
        .reset     (reset),
        .flag      (flagD),
        .flag_sync (d_s)
    );

    // Flag decode and saturating candidate code, computed one bit wider than the code
    logic              mv_up;
    logic              mv_dn;
    dir_t              mv;
    logic              eval;
    logic [CODE_W-1:0] delta;
    logic [CODE_W:0]   sum;
    logic [CODE_W:0]   diff;
    logic [CODE_W-1:0] up_sat;
    logic [CODE_W-1:0] dn_sat;
    logic [CODE_W-1:0] cand;
    logic              changed;

    assign mv_up   = u_s & ~d_s;
    assign mv_dn   = d_s & ~u_s;
    assign mv      = mv_up ? DIR_UP : (mv_dn ? DIR_DN : DIR_NONE);
    assign eval    = (settle_q == '0);
    assign delta   = (state_q == ST_SEARCH) ? step_q : CODE_W'(1);
    assign sum     = {1'b0, code_q} + {1'b0, delta};
    assign diff    = {1'b0, code_q} - {1'b0, delta};
    assign up_sat  = sum[CODE_W]  ? {CODE_W{1'b1}} : sum[CODE_W-1:0];
    assign dn_sat  = diff[CODE_W] ? {CODE_W{1'b0}} : diff[CODE_W-1:0];
    assign cand    = mv_up ? up_sat : (mv_dn ? dn_sat : code_q);
    assign changed = (cand != code_q);

    always_ff @(posedge IN_clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            dir_q      <= DIR_NONE;
            code_q     <= MID_CODE;
            step_q     <= INIT_STEP;
            settle_q   <= '0;
            lock_cnt_q <= '0;
            run_cnt_q  <= '0;
            upd_q      <= 1'b0;
            lock_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            code_q     <= code_d;
            step_q     <= step_d;
            settle_q   <= settle_d;
            lock_cnt_q <= lock_cnt_d;
            run_cnt_q  <= run_cnt_d;
            upd_q      <= upd_d;
            lock_q     <= lock_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        code_d     = code_q;
        step_d     = step_q;
        settle_d   = settle_q;
        lock_cnt_d = lock_cnt_q;
        run_cnt_d  = run_cnt_q;
        upd_d      = 1'b0;

        if (!freeze) begin
            if (!eval) begin
                settle_d = settle_q - SET_W'(1);
            end

            case (state_q)
                ST_IDLE: begin
                    code_d  = MID_CODE;
                    step_d  = INIT_STEP;
                    state_d = ST_SEARCH;
                end
                ST_SEARCH: begin
                    if (eval) begin
                        step_d = step_q >> 1;
                        if (step_q == CODE_W'(1)) begin
                            state_d    = ST_TRACK;
                            lock_cnt_d = '0;
                            dir_d      = DIR_NONE;
                        end
                    end
                end
                ST_TRACK: begin
                    if (eval) begin
                        if ((mv == DIR_NONE) || (mv != dir_q)) begin
                            lock_cnt_d = lock_cnt_q + LCK_W'(1);
                        end else begin
                            lock_cnt_d = '0;
                        end
                        if (mv != DIR_NONE) begin
                            dir_d = mv;
                        end
                        if (lock_cnt_d == LOCK_TGT) begin
                            state_d   = ST_LOCKED;
                            run_cnt_d = '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    // Holds leave the run untouched; the triggering move is still applied
                    if (eval && (mv != DIR_NONE)) begin
                        if ((run_cnt_q != '0) && (mv == dir_q)) begin
                            run_cnt_d = run_cnt_q + RUN_W'(1);
                        end else begin
                            run_cnt_d = RUN_W'(1);
                        end
                        dir_d = mv;
                        if (run_cnt_d == RUN_TGT) begin
                            state_d    = ST_SEARCH;
                            step_d     = REACQ_STEP;
                            run_cnt_d  = '0;
                            lock_cnt_d = '0;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            if (eval && (state_q != ST_IDLE) && changed) begin
                code_d   = cand;
                upd_d    = 1'b1;
                settle_d = SETTLE_LD;
            end
        end
    end

    assign lock_d   = (state_d == ST_LOCKED);
    assign dco_code = code_q;
    assign code_upd = upd_q;
    assign lock     = lock_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_adpll_loop_ctrl.sv
// Directed bench for adpll_loop_ctrl: search sequence, lock latency, unlock, freeze and reset.
module tb_adpll_loop_ctrl;

    logic       IN_clk = 1'b0;
    logic       reset;
    logic       flagU;
    logic       flagD;
    logic       freeze;
    logic [7:0] dco_code;
    logic       code_upd;
    logic       lock;
    logic [1:0] state_o;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 IN_clk = ~IN_clk;

    adpll_loop_ctrl #(
        .CODE_W     (8),
        .SETTLE     (3),
        .LOCK_CNT   (8),
        .UNLOCK_RUN (4)
    ) dut (
        .IN_clk   (IN_clk),
        .reset    (reset),
        .flagU    (flagU),
        .flagD    (flagD),
        .freeze   (freeze),
        .dco_code (dco_code),
        .code_upd (code_upd),
        .lock     (lock),
        .state_o  (state_o)
    );

    typedef struct {
        logic       u;
        logic       d;
        logic [7:0] code;
        logic [1:0] st;
        logic       lk;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " code"},  int'(dco_code), 128);
        check({tag, " upd"},   int'(code_upd), 0);
        check({tag, " lock"},  int'(lock), 0);
        check({tag, " state"}, int'(state_o), 0);
    endtask

    // Reset, then hold freeze while the synchronizers fill with the requested flags
    task automatic start(input logic u, input logic d, input string tag);
        reset  = 1'b0;
        freeze = 1'b1;
        flagU  = u;
        flagD  = d;
        repeat (2) @(negedge IN_clk);
        check_reset_vals(tag);
        reset = 1'b1;
        repeat (3) @(negedge IN_clk);
        check({tag, " idle_frozen"}, int'(state_o), 0);
        freeze = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v, input string name);
        int waited;
        bit seen;
        waited = 0;
        seen   = 1'b0;
        flagU  = v.u;
        flagD  = v.d;
        while (!seen && waited < 20) begin
            @(negedge IN_clk);
            waited++;
            if (code_upd) seen = 1'b1;
        end
        check({name, " upd_seen"}, int'(seen), 1);
        check({name, " code"},  int'(dco_code), int'(v.code));
        check({name, " state"}, int'(state_o), int'(v.st));
        check({name, " lock"},  int'(lock), int'(v.lk));
    endtask

    task automatic hold_cycles(input int n, input string name);
        int upd_n;
        upd_n = 0;
        flagU = 1'b0;
        flagD = 1'b0;
        repeat (n) begin
            @(negedge IN_clk);
            if (code_upd) upd_n++;
        end
        check({name, " upd"},   upd_n, 0);
        check({name, " state"}, int'(state_o), 3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v_up[7];
        vec_t v_unl[4];
        vec_t v_reacq[5];
        int   cnt;
        int   upd_n;
        int   lock_at;
        int   first_lock;
        bit   seen;

        v_up[0] = '{1'b1, 1'b0, 8'd192, 2'd1, 1'b0};
        v_up[1] = '{1'b1, 1'b0, 8'd224, 2'd1, 1'b0};
        v_up[2] = '{1'b1, 1'b0, 8'd240, 2'd1, 1'b0};
        v_up[3] = '{1'b1, 1'b0, 8'd248, 2'd1, 1'b0};
        v_up[4] = '{1'b1, 1'b0, 8'd252, 2'd1, 1'b0};
        v_up[5] = '{1'b1, 1'b0, 8'd254, 2'd1, 1'b0};
        v_up[6] = '{1'b1, 1'b0, 8'd255, 2'd2, 1'b0};

        v_unl[0] = '{1'b0, 1'b1, 8'd100, 2'd3, 1'b1};
        v_unl[1] = '{1'b0, 1'b1, 8'd99,  2'd3, 1'b1};
        v_unl[2] = '{1'b0, 1'b1, 8'd98,  2'd3, 1'b1};
        v_unl[3] = '{1'b0, 1'b1, 8'd97,  2'd1, 1'b0};

        v_reacq[0] = '{1'b1, 1'b0, 8'd113, 2'd1, 1'b0};
        v_reacq[1] = '{1'b1, 1'b0, 8'd121, 2'd1, 1'b0};
        v_reacq[2] = '{1'b1, 1'b0, 8'd125, 2'd1, 1'b0};
        v_reacq[3] = '{1'b1, 1'b0, 8'd127, 2'd1, 1'b0};
        v_reacq[4] = '{1'b1, 1'b0, 8'd128, 2'd2, 1'b0};

        reset  = 1'b0;
        freeze = 1'b1;
        flagU  = 1'b0;
        flagD  = 1'b0;

        // Constant up: full binary search to the top, then saturated tracking
        start(1'b1, 1'b0, "rst0");
        @(negedge IN_clk);
        check("idle_exit state", int'(state_o), 1);
        check("idle_exit code",  int'(dco_code), 128);
        check("idle_exit upd",   int'(code_upd), 0);
        for (int i = 0; i < 7; i++) apply_vec(v_up[i], $sformatf("up%0d", i));
        upd_n = 0;
        repeat (20) begin
            @(negedge IN_clk);
            if (code_upd) upd_n++;
        end
        check("sat upd",   upd_n, 0);
        check("sat code",  int'(dco_code), 255);
        check("sat state", int'(state_o), 2);

        // Asynchronous reset in TRACK, away from any clock edge
        @(posedge IN_clk);
        #2 reset = 1'b0;
        #1 check_reset_vals("async_rst");

        // Freeze in the middle of the search
        start(1'b1, 1'b0, "rst1");
        apply_vec(v_up[0], "frz_a");
        apply_vec(v_up[1], "frz_b");
        freeze = 1'b1;
        upd_n  = 0;
        repeat (10) begin
            @(negedge IN_clk);
            if (code_upd) upd_n++;
        end
        check("frozen upd",   upd_n, 0);
        check("frozen code",  int'(dco_code), 224);
        check("frozen state", int'(state_o), 1);
        freeze = 1'b0;
        cnt  = 0;
        seen = 1'b0;
        while (!seen && cnt < 20) begin
            @(negedge IN_clk);
            cnt++;
            if (code_upd) seen = 1'b1;
        end
        check("resume latency", cnt, 4);
        check("resume code", int'(dco_code), 240);
        for (int i = 3; i < 7; i++) apply_vec(v_up[i], $sformatf("resume%0d", i));

        // DCO model with target between 100 and 101: converge and lock
        start(1'b0, 1'b1, "rst2");
        cnt     = 0;
        upd_n   = 0;
        lock_at = -1;
        while (lock_at < 0 && cnt < 200) begin
            @(negedge IN_clk);
            cnt++;
            if (code_upd) upd_n++;
            if (lock) lock_at = cnt;
            flagU = (dco_code <= 8'd100);
            flagD = (dco_code >  8'd100);
        end
        check("lock latency", lock_at, 58);
        check("lock upd count", upd_n, 15);
        check("lock code", int'(dco_code), 101);
        check("lock state", int'(state_o), 3);
        check("lock within1", int'((dco_code >= 8'd99) && (dco_code <= 8'd101)), 1);

        // Four dn moves with holds in between drop lock into re-acquisition
        apply_vec(v_unl[0], "unl0");
        hold_cycles(6, "hold0");
        apply_vec(v_unl[1], "unl1");
        hold_cycles(6, "hold1");
        apply_vec(v_unl[2], "unl2");
        hold_cycles(6, "hold2");
        apply_vec(v_unl[3], "unl3");
        for (int i = 0; i < 5; i++) apply_vec(v_reacq[i], $sformatf("reacq%0d", i));

        // Both flags high in TRACK: holds only, lock counter runs to LOCKED
        flagU      = 1'b1;
        flagD      = 1'b1;
        upd_n      = 0;
        first_lock = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge IN_clk);
            if (code_upd) upd_n++;
            if (state_o == 2'd3 && first_lock < 0) first_lock = k;
        end
        check("both upd", upd_n, 0);
        check("both code", int'(dco_code), 128);
        check("both lock cycle", first_lock, 11);
        check("both lock", int'(lock), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
